quant_int8_sched: RTL and testbench

//  Layer-level sequencer for the 8-channel INT8 requantizer. Latches per-layer mult/shift/zero_point,

---
 rtl/quant_int8_sched_if.sv | 35 +++
 rtl/quant_int8_sched.sv | 192 +++++++++++++++++++
 tb/tb_quant_int8_sched.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quant_int8_sched_if.sv
// quant_int8_sched_if -- data-path handshake bundle for the INT8 requant sequencer.
//
// Signals
//   acc_vld / acc_rdy             accumulator beat handshake (8 lanes per beat)
//   q_in_vld                      quantizer input valid (= accepted accumulator beat)
//   q_mult / q_shift / q_zp       per-layer requant parameters driven to the quantizer
//   q_out_vld / q_out_data        quantizer result, 8 quantized bytes {ch7..ch0}
//   out_vld / out_rdy / out_data  output FIFO head towards the write stage
//
// Modports
//   slave   the sequencer (quant_int8_sched)
//   master  the surrounding accumulator / quantizer / write-stage environment
interface quant_int8_sched_if;
   logic        acc_vld;
   logic        acc_rdy;
   logic        q_in_vld;
   logic [14:0] q_mult;
   logic [7:0]  q_shift;
   logic [7:0]  q_zp;
   logic        q_out_vld;
   logic [63:0] q_out_data;
   logic        out_vld;
   logic        out_rdy;
   logic [63:0] out_data;

   modport slave (
      input  acc_vld, q_out_vld, q_out_data, out_rdy,
      output acc_rdy, q_in_vld, q_mult, q_shift, q_zp, out_vld, out_data
   );

   modport master (
      output acc_vld, q_out_vld, q_out_data, out_rdy,
      input  acc_rdy, q_in_vld, q_mult, q_shift, q_zp, out_vld, out_data
   );
endinterface

// File: rtl/quant_int8_sched.sv
// quant_int8_sched -- layer-level sequencer for the 8-channel INT8 requantizer.
// Latches the layer parameters, meters accumulator beats into the fixed-latency
// quantizer against output-FIFO credit, buffers results and pulses done once the
// last beat of the layer has been popped downstream.
//
// Ports
//   sclk, s_rst_n     clock, asynchronous active-low reset
//   cfg_start         one-cycle layer start (ignored unless idle)
//   cfg_mult/shift/zp layer requant parameters, cfg_beats beats in the layer
//   busy, done, err   status: layer active, end-of-layer pulse, sticky protocol error
//   bus               quant_int8_sched_if.slave: accumulator, quantizer and output streams
//   stall_cnt         output-stall cycle counter (only with QUANT_SCHED_STAT_EN)
//
// Build option: define QUANT_SCHED_STAT_EN to add the stall_cnt port and counter.
//
// state  | meaning
// IDLE   | waiting for cfg_start, parameters latched on start
// LOAD   | drive latched parameters onto q_mult/q_shift/q_zp
// RUN    | accept accumulator beats while beats remain and credit allows
// DRAIN  | all beats issued, wait for the last one to leave the FIFO
// DONE   | one-cycle done pulse
module quant_int8_sched #(
   parameter int PIPE_LAT   = 5,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16
) (
   input  logic             sclk,
   input  logic             s_rst_n,
   input  logic             cfg_start,
   input  logic [14:0]      cfg_mult,
   input  logic [7:0]       cfg_shift,
   input  logic [7:0]       cfg_zp,
   input  logic [CNT_W-1:0] cfg_beats,
   quant_int8_sched_if.slave bus,
   output logic             busy,
   output logic             done,
   output logic             err
`ifdef QUANT_SCHED_STAT_EN
   ,output logic [31:0]     stall_cnt
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CW    = PTR_W + 1;

   // Credit only prevents overflow if the FIFO can hold a full quantizer pipeline.
   if (FIFO_DEPTH < PIPE_LAT + 1) begin : g_bad_depth
      $error("FIFO_DEPTH must be at least PIPE_LAT+1");
   end

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  beats, issued, popped;
   logic [14:0]       lat_mult, q_mult_r;
   logic [7:0]        lat_shift, lat_zp, q_shift_r, q_zp_r;
   logic [CW-1:0]     inflight, fifo_cnt;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [63:0]       mem [FIFO_DEPTH];
   logic              err_r, run_rdy;
   logic              xfer, pop, push, fifo_full, credit_ok, start_ok, last_pop;

   assign start_ok  = (state == S_IDLE) & cfg_start;
   assign xfer      = bus.acc_vld & run_rdy;
   assign pop       = bus.out_vld & bus.out_rdy;
   assign fifo_full = (fifo_cnt == CW'(FIFO_DEPTH));
   assign push      = bus.q_out_vld & (~fifo_full | pop);
   // Beats already owed to the FIFO plus those stored must leave room for one more.
   assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_cnt}) < (CW + 1)'(FIFO_DEPTH);
   // Counting the pop of this cycle lets done follow the final pop by exactly one cycle.
   assign last_pop  = ({1'b0, popped} + (CNT_W + 1)'(pop)) >= {1'b0, beats};

   assign bus.acc_rdy  = run_rdy;
   assign bus.q_in_vld = xfer;
   assign bus.q_mult   = q_mult_r;
   assign bus.q_shift  = q_shift_r;
   assign bus.q_zp     = q_zp_r;
   assign bus.out_vld  = (fifo_cnt != '0);
   assign bus.out_data = mem[rd_ptr];
   assign err          = err_r;

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (cfg_start) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = (beats == '0) ? S_DONE : S_RUN;
         S_RUN:   if (issued == beats) state_nxt = S_DRAIN;
         S_DRAIN: if (last_pop) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      run_rdy = 1'b0;
      case (state)
         S_LOAD:  busy = 1'b1;
         S_RUN: begin
            busy    = 1'b1;
            run_rdy = (issued < beats) & credit_ok;
         end
         S_DRAIN: busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         beats     <= '0;
         lat_mult  <= '0;
         lat_shift <= '0;
         lat_zp    <= '0;
         q_mult_r  <= '0;
         q_shift_r <= '0;
         q_zp_r    <= '0;
         issued    <= '0;
         popped    <= '0;
      end else begin
         if (start_ok) begin
            beats     <= cfg_beats;
            lat_mult  <= cfg_mult;
            lat_shift <= cfg_shift;
            lat_zp    <= cfg_zp;
            issued    <= '0;
            popped    <= '0;
         end else begin
            if (xfer)        issued <= issued + CNT_W'(1);
            if (pop && busy) popped <= popped + CNT_W'(1);
         end
         if (state == S_LOAD) begin
            q_mult_r  <= lat_mult;
            q_shift_r <= lat_shift;
            q_zp_r    <= lat_zp;
         end
      end
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         inflight <= '0;
         err_r    <= 1'b0;
      end else begin
         if (xfer && !bus.q_out_vld)
            inflight <= inflight + CW'(1);
         else if (!xfer && bus.q_out_vld && inflight != '0)
            inflight <= inflight - CW'(1);
         if (bus.q_out_vld && inflight == '0) err_r <= 1'b1;
      end
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: ;
         endcase
      end
   end

   // Storage needs no reset: out_vld masks any entry not yet written.
   always_ff @(posedge sclk) begin
      if (push) mem[wr_ptr] <= bus.q_out_data;
   end

`ifdef QUANT_SCHED_STAT_EN
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n)
         stall_cnt <= '0;
      else if (start_ok)
         stall_cnt <= '0;
      else if ((state == S_RUN || state == S_DRAIN) && bus.out_vld && !bus.out_rdy
               && stall_cnt != '1)
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_quant_int8_sched.sv
module tb_quant_int8_sched;
   localparam int PIPE_LAT   = 5;
   localparam int FIFO_DEPTH = 8;
   localparam int CNT_W      = 16;

   logic             sclk = 1'b0;
   logic             s_rst_n = 1'b1;
   logic             cfg_start = 1'b0;
   logic [14:0]      cfg_mult = '0;
   logic [7:0]       cfg_shift = '0;
   logic [7:0]       cfg_zp = '0;
   logic [CNT_W-1:0] cfg_beats = '0;
   logic             busy, done, err;
`ifdef QUANT_SCHED_STAT_EN
   logic [31:0]      stall_cnt;
`endif

   quant_int8_sched_if bus();

   quant_int8_sched #(.PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
      .sclk      (sclk),
      .s_rst_n   (s_rst_n),
      .cfg_start (cfg_start),
      .cfg_mult  (cfg_mult),
      .cfg_shift (cfg_shift),
      .cfg_zp    (cfg_zp),
      .cfg_beats (cfg_beats),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .err       (err)
`ifdef QUANT_SCHED_STAT_EN
      ,.stall_cnt(stall_cnt)
`endif
   );

   always #5 sclk = ~sclk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // Behavioural quantizer: every accepted beat reappears PIPE_LAT cycles later
   // carrying a fresh random word, which is also queued as the expected output.
   logic        pv [PIPE_LAT+1];
   logic [63:0] pd [PIPE_LAT+1];
   logic        inj_vld = 1'b0;
   logic [63:0] inj_data = '0;
   logic [63:0] exp_q [$];
   logic [63:0] got_q [$];
   logic [63:0] w;
   int xfer_cnt, done_cnt, stall_ref, last_pop_cyc, done_cyc;
   bit rnd_vld = 0, rnd_rdy = 0;

   assign bus.q_out_vld  = pv[PIPE_LAT] | inj_vld;
   assign bus.q_out_data = pv[PIPE_LAT] ? pd[PIPE_LAT] : inj_data;

   always @(posedge sclk) cyc <= cyc + 1;

   always @(negedge sclk) begin
      if (!s_rst_n) begin
         for (int i = 0; i <= PIPE_LAT; i++) pv[i] = 1'b0;
      end else begin
         for (int i = PIPE_LAT; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
         end
         pv[0] = bus.q_in_vld;
         pd[0] = '0;
         if (bus.q_in_vld) begin
            w = {$urandom, $urandom};
            pd[0] = w;
            exp_q.push_back(w);
            xfer_cnt++;
         end
      end
      if (bus.out_vld && bus.out_rdy) begin
         got_q.push_back(bus.out_data);
         last_pop_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy && bus.out_vld && !bus.out_rdy) stall_ref++;
   end

   task automatic tick();
      @(posedge sclk);
      #1;
      if (rnd_vld) bus.acc_vld = ($urandom_range(0, 1) == 1);
      if (rnd_rdy) bus.out_rdy = ($urandom_range(0, 1) == 1);
   endtask

   task automatic clear_mon();
      exp_q.delete();
      got_q.delete();
      xfer_cnt = 0;
      done_cnt = 0;
      stall_ref = 0;
      last_pop_cyc = -100;
      done_cyc = -1;
   endtask

   task automatic apply_reset();
      bus.acc_vld = 1'b0;
      bus.out_rdy = 1'b0;
      cfg_start = 1'b0;
      inj_vld = 1'b0;
      rnd_vld = 0;
      rnd_rdy = 0;
      s_rst_n = 1'b1;
      #1;
      s_rst_n = 1'b0;
      repeat (3) @(posedge sclk);
      #1;
      s_rst_n = 1'b1;
   endtask

   task automatic start_layer(input int beats, input logic [14:0] m,
                              input logic [7:0] sh, input logic [7:0] zp);
      cfg_beats = CNT_W'(beats);
      cfg_mult  = m;
      cfg_shift = sh;
      cfg_zp    = zp;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic wait_done(input int max, output bit ok);
      ok = 0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (done_cnt > 0) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge sclk);
      n_chk++;
      if ({busy, done, err, bus.acc_rdy, bus.out_vld} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_status busy/done/err/acc_rdy/out_vld=%b required 00000",
                  {busy, done, err, bus.acc_rdy, bus.out_vld});
      end
      n_chk++;
      if ({bus.q_mult, bus.q_shift, bus.q_zp} !== 31'b0) begin
         n_fail++;
         $display("FAIL reset_params got %h/%h/%h required 0/0/0", bus.q_mult, bus.q_shift, bus.q_zp);
      end
`ifdef QUANT_SCHED_STAT_EN
      n_chk++;
      if (stall_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_stall_cnt got %0d required 0", stall_cnt);
      end
`endif
   endtask

   task automatic test_basic();
      logic [14:0] m;
      logic [7:0]  sh, zp;
      bit ok, bad;
      m = 15'($urandom);
      sh = 8'($urandom);
      zp = 8'($urandom);
      clear_mon();
      bus.acc_vld = 1'b1;
      bus.out_rdy = 1'b1;
      start_layer(4, m, sh, zp);
      @(negedge sclk);
      n_chk++;
      if (bus.acc_rdy !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL t1_load acc_rdy=%b busy=%b required 0 1", bus.acc_rdy, busy);
      end
      tick();
      @(negedge sclk);
      n_chk++;
      if (bus.acc_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL t1_rdy_latency acc_rdy=%b two cycles after start, required 1", bus.acc_rdy);
      end
      n_chk++;
      if ({bus.q_mult, bus.q_shift, bus.q_zp} !== {m, sh, zp}) begin
         n_fail++;
         $display("FAIL t1_params got %h/%h/%h required %h/%h/%h",
                  bus.q_mult, bus.q_shift, bus.q_zp, m, sh, zp);
      end
      wait_done(100, ok);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL t1_timeout done=%0d pulses required 1 within 100 cycles", done_cnt);
      end
      n_chk++;
      if (xfer_cnt != 4) begin
         n_fail++;
         $display("FAIL t1_transfers got %0d required 4", xfer_cnt);
      end
      bad = (got_q.size() != 4) || (exp_q.size() != 4);
      if (!bad) foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad = 1;
      n_chk++;
      if (bad) begin
         n_fail++;
         $display("FAIL t1_data popped %0d beats required 4 matching in order", got_q.size());
      end
      n_chk++;
      if (done_cyc != last_pop_cyc + 1) begin
         n_fail++;
         $display("FAIL t1_done_timing done at %0d required %0d", done_cyc, last_pop_cyc + 1);
      end
      tick();
      tick();
      @(negedge sclk);
      n_chk++;
      if (busy !== 1'b0 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL t1_after busy=%b done pulses=%0d required 0 and 1", busy, done_cnt);
      end
      bus.acc_vld = 1'b0;
   endtask

   task automatic test_backpressure();
      bit ok, bad;
      clear_mon();
      bus.acc_vld = 1'b1;
      bus.out_rdy = 1'b0;
      start_layer(20, 15'($urandom), 8'($urandom), 8'($urandom));
      repeat (30) tick();
      @(negedge sclk);
      n_chk++;
      if (xfer_cnt != FIFO_DEPTH) begin
         n_fail++;
         $display("FAIL t2_credit transfers=%0d under backpressure required %0d", xfer_cnt, FIFO_DEPTH);
      end
      n_chk++;
      if (bus.acc_rdy !== 1'b0 || bus.out_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL t2_stalled acc_rdy=%b out_vld=%b required 0 1", bus.acc_rdy, bus.out_vld);
      end
      bus.out_rdy = 1'b1;
      wait_done(200, ok);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL t2_timeout no done within 200 cycles, popped %0d", got_q.size());
      end
      bad = (got_q.size() != 20) || (exp_q.size() != 20);
      if (!bad) foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad = 1;
      n_chk++;
      if (bad) begin
         n_fail++;
         $display("FAIL t2_data popped %0d issued %0d required 20 matching in order",
                  got_q.size(), exp_q.size());
      end
      n_chk++;
      if (done_cyc != last_pop_cyc + 1) begin
         n_fail++;
         $display("FAIL t2_done_timing done at %0d required %0d", done_cyc, last_pop_cyc + 1);
      end
      bus.acc_vld = 1'b0;
   endtask

   task automatic test_zero_beats();
      int done_at, n_done;
      bit seen_rdy, seen_ov;
      clear_mon();
      done_at = -1;
      n_done = 0;
      seen_rdy = 0;
      seen_ov = 0;
      bus.acc_vld = 1'b1;
      bus.out_rdy = 1'b1;
      cfg_beats = '0;
      cfg_start = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         cfg_start = 1'b0;
         @(negedge sclk);
         if (done) begin
            n_done++;
            if (done_at < 0) done_at = i;
         end
         if (bus.acc_rdy) seen_rdy = 1;
         if (bus.out_vld) seen_ov = 1;
      end
      n_chk++;
      if (done_at != 2 || n_done != 1) begin
         n_fail++;
         $display("FAIL t3_done first at cycle %0d (%0d pulses) required cycle 2, 1 pulse", done_at, n_done);
      end
      n_chk++;
      if (seen_rdy || seen_ov) begin
         n_fail++;
         $display("FAIL t3_quiet acc_rdy seen=%0d out_vld seen=%0d required 0 0", seen_rdy, seen_ov);
      end
      bus.acc_vld = 1'b0;
   endtask

   task automatic test_start_ignored();
      logic [14:0] m1;
      bit bad, drift, ok;
      m1 = 15'($urandom);
      clear_mon();
      rnd_vld = 1;
      rnd_rdy = 1;
      start_layer(12, m1, 8'($urandom), 8'($urandom));
      repeat (6) tick();
      cfg_mult  = ~m1;
      cfg_beats = CNT_W'(3);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      drift = 0;
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge sclk);
         if (bus.q_mult !== m1) drift = 1;
         if (done) begin
            ok = 1;
            break;
         end
         tick();
      end
      n_chk++;
      if (!ok || drift) begin
         n_fail++;
         $display("FAIL t4_params done_seen=%0d q_mult changed=%0d required 1 0", ok, drift);
      end
      rnd_vld = 0;
      bus.acc_vld = 1'b0;
      repeat (4) tick();
      @(negedge sclk);
      bad = (got_q.size() != 12) || (exp_q.size() != 12);
      if (!bad) foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad = 1;
      n_chk++;
      if (bad) begin
         n_fail++;
         $display("FAIL t4_data popped %0d issued %0d required 12 matching", got_q.size(), exp_q.size());
      end
      n_chk++;
      if (busy !== 1'b0 || done_cnt != 1 || bus.q_mult !== m1) begin
         n_fail++;
         $display("FAIL t4_after busy=%b done pulses=%0d q_mult=%h required 0 1 %h",
                  busy, done_cnt, bus.q_mult, m1);
      end
      rnd_rdy = 0;
   endtask

   task automatic test_err_reset();
      apply_reset();
      clear_mon();
      inj_data = {$urandom, $urandom};
      inj_vld = 1'b1;
      tick();
      inj_vld = 1'b0;
      @(negedge sclk);
      n_chk++;
      if (err !== 1'b1 || bus.out_vld !== 1'b1 || bus.out_data !== inj_data) begin
         n_fail++;
         $display("FAIL t5_spurious err=%b out_vld=%b data=%h required 1 1 %h",
                  err, bus.out_vld, bus.out_data, inj_data);
      end
      repeat (5) tick();
      bus.out_rdy = 1'b1;
      tick();
      bus.out_rdy = 1'b0;
      @(negedge sclk);
      n_chk++;
      if (err !== 1'b1 || bus.out_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL t5_sticky err=%b out_vld=%b required 1 0", err, bus.out_vld);
      end
      bus.acc_vld = 1'b1;
      bus.out_rdy = 1'b1;
      start_layer(10, 15'h1234, 8'h5a, 8'ha5);
      repeat (4) tick();
      s_rst_n = 1'b0;
      @(negedge sclk);
      n_chk++;
      if ({busy, done, err, bus.acc_rdy, bus.out_vld} !== 5'b0
          || {bus.q_mult, bus.q_shift, bus.q_zp} !== 31'b0) begin
         n_fail++;
         $display("FAIL t5_reset_mid_run status=%b params=%h/%h/%h required all zero",
                  {busy, done, err, bus.acc_rdy, bus.out_vld}, bus.q_mult, bus.q_shift, bus.q_zp);
      end
      bus.acc_vld = 1'b0;
      tick();
      s_rst_n = 1'b1;
      repeat (12) tick();
      @(negedge sclk);
      n_chk++;
      if ({busy, err, bus.out_vld} !== 3'b0) begin
         n_fail++;
         $display("FAIL t5_post_reset busy/err/out_vld=%b required 000", {busy, err, bus.out_vld});
      end
      bus.out_rdy = 1'b0;
   endtask

   task automatic test_stall_stat();
      bit ok, bad;
      clear_mon();
      rnd_vld = 1;
      rnd_rdy = 1;
      start_layer(10, 15'($urandom), 8'($urandom), 8'($urandom));
      wait_done(400, ok);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL t6_timeout no done within 400 cycles, popped %0d", got_q.size());
      end
      bad = (got_q.size() != 10) || (exp_q.size() != 10);
      if (!bad) foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad = 1;
      n_chk++;
      if (bad) begin
         n_fail++;
         $display("FAIL t6_data popped %0d issued %0d required 10 matching", got_q.size(), exp_q.size());
      end
`ifdef QUANT_SCHED_STAT_EN
      n_chk++;
      if (stall_cnt !== 32'(stall_ref)) begin
         n_fail++;
         $display("FAIL t6_stall_cnt got %0d required %0d", stall_cnt, stall_ref);
      end
`endif
      rnd_vld = 0;
      rnd_rdy = 0;
      bus.acc_vld = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [14:0] m;
      logic [7:0]  sh, zp;
      int nb;
      bit ok, bad;
      for (int l = 0; l < 3; l++) begin
         clear_mon();
         nb = $urandom_range(1, 24);
         m = 15'($urandom);
         sh = 8'($urandom);
         zp = 8'($urandom);
         rnd_vld = 1;
         rnd_rdy = 1;
         start_layer(nb, m, sh, zp);
         wait_done(600, ok);
         bad = !ok || (got_q.size() != nb) || (exp_q.size() != nb);
         if (!bad) foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad = 1;
         n_chk++;
         if (bad) begin
            n_fail++;
            $display("FAIL b2b_data layer %0d done=%0d popped %0d issued %0d required %0d",
                     l, ok, got_q.size(), exp_q.size(), nb);
         end
         n_chk++;
         if (done_cyc != last_pop_cyc + 1 || {bus.q_mult, bus.q_shift, bus.q_zp} !== {m, sh, zp}) begin
            n_fail++;
            $display("FAIL b2b_done layer %0d done at %0d last pop %0d params %h/%h/%h required %h/%h/%h",
                     l, done_cyc, last_pop_cyc, bus.q_mult, bus.q_shift, bus.q_zp, m, sh, zp);
         end
      end
      rnd_vld = 0;
      rnd_rdy = 0;
      bus.acc_vld = 1'b0;
   endtask

   initial begin
      for (int i = 0; i <= PIPE_LAT; i++) begin
         pv[i] = 1'b0;
         pd[i] = '0;
      end
      clear_mon();
      apply_reset();
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_beats();
      test_start_ignored();
      test_err_reset();
      test_stall_stat();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation time limit reached, %0d checks done", n_chk);
      $fatal(1, "time limit");
   end
endmodule
